uart_core_p: RTL and testbench
==============================

// Module: uart_core_p
// PURPOSE
//  Parametrised full-duplex UART: single clk domain, internal baud counter, independent TX/RX FIFOs.
//  Adds runtime parity/stop config, RX parity/framing/overrun error flags, valid/ready FIFO ports
//  and level interrupts. Sits behind the peripheral register bus; tx/rx go to the io mux.
// PARAMETERS
//  DW     8  data bits per frame, legal 5..8
//  DEPTH  8  entries per FIFO, power of 2, >=2; AW = $clog2(DEPTH)
//  CW     16 baud divider width
// PORTS
//  clk      in  1        peripheral clock
//  rst      in  1        asynchronous reset, active-high
//  en       in  1        block enable; 0 = both FSMs held in IDLE, tx=1, FIFOs keep contents
//  clear    in  1        1-cycle pulse: flush both FIFOs, clear error flags
//  div      in  CW       bit period = div+1 clk cycles; legal div>=3
//  par      in  2        0 none, 1 even, 2 odd, 3 none (reserved)
//  stop2    in  1        1 = two stop bits on TX, RX checks first only
//  wvalid   in  1        TX FIFO write strobe
//  wready   out 1        !wfull
//  wdata    in  DW       TX char
//  rvalid   out 1        !rempty
//  rready   in  1        RX FIFO pop strobe
//  rdata    out DW       RX FIFO head, valid while rvalid
//  rperr    out 1        parity error of head entry (stored alongside data)
//  rferr    out 1        framing error of head entry
//  ovr      out 1        sticky: frame received while RX FIFO full; cleared by clear
//  wcnt     out AW+1     TX FIFO occupancy 0..DEPTH
//  rcnt     out AW+1     RX FIFO occupancy 0..DEPTH
//  wlvl     in  AW+1     wintr asserts when wcnt <= wlvl
//  rlvl     in  AW+1     rintr asserts when rcnt >= rlvl, rlvl!=0
//  wintr    out 1        registered TX-low level interrupt
//  rintr    out 1        registered RX-high level interrupt
//  tx       out 1        serial out, idle 1
//  rx       in  1        serial in, asynchronous
// BEHAVIOUR
//  Reset: tx=1, FIFOs empty, wcnt=rcnt=0, rvalid=0, wready=1, ovr=0, wintr=1 (0<=wlvl), rintr=0, rperr=rferr=0.
//  Baud: per-FSM counter loads div on each bit boundary, decrements to 0; bit boundary at 0.
//  TX FSM IDLE->START->DATA(DW bits, LSB first)->[PARITY]->STOP(1 or 2)->IDLE.
//   IDLE leaves when en && !wempty; head popped on entry to START (wcnt drops that cycle).
//   tx registered; first START bit drives 0 one cycle after leaving IDLE.
//   Back-to-back: STOP->START directly if FIFO non-empty, no idle gap.
//  RX: rx passes 2-flop sync (reset 1). IDLE detects 1->0 on synced rx.
//   START: wait (div+1)>>1 cycles, resample; if 1 -> glitch, back to IDLE, nothing stored.
//   DATA/PARITY/STOP sampled every div+1 cycles from mid-start.
//   At STOP sample: write {ferr=~rx, perr, data} if !rfull, else set ovr, discard.
//   Returns to IDLE after stop sample (half-bit early, allows rate mismatch).
//  Parity: even -> parity bit = ^data; odd -> ~^data; perr = received != expected; none -> perr=0.
//  FIFO: pointers AW+1 wide, wrap naturally; cnt = wp-rp. Write when full ignored (TX: wvalid&&!wready dropped).
//   Simultaneous push+pop when full or empty: both honoured only if legal at cycle start;
//   pop on empty ignored. clear has priority over push/pop same cycle.
//  Config change (div/par/stop2) mid-frame: undefined frame, FSM must still return to IDLE.
//  en falling mid-frame: FSMs abort to IDLE next cycle; aborted TX char is lost (already popped).
//  Interrupts registered, updated every cycle from next-state counts; no hysteresis.
// CONFIGURATION
//  UART_LOOPBACK_EN defined: extra input port lpbk; when 1, RX sync input = internal tx and
//   tx pin held 1. Undefined: no lpbk port, RX always from rx pin.
// STRUCTURE
//  uart_pkg: typedef enum tx_st_e {TX_IDLE,TX_START,TX_DATA,TX_PAR,TX_STOP};
//   rx_st_e likewise; enum par_e {PAR_NONE,PAR_EVEN,PAR_ODD}; localparam DIV_MIN=3.
//  Sub-module uart_fifo #(W,DEPTH): sync FIFO with cnt/full/empty, clear; instanced twice
//   (TX W=DW, RX W=DW+2).
// TESTING
//  1 Reset: rst=1 mid-TX -> tx=1, wcnt=0, rintr=0, wintr=1 within 0 cycles after rst rises.
//  2 Loop tx->rx, div=7, par=even, DW=8: push 0xA5,0x3C -> rdata 0xA5 then 0x3C, perr=ferr=0,
//    tx frame 11 bits x 8 cycles each, no gap.
//  3 Parity: drive rx frame 0x55 with wrong even parity -> rperr=1 with rdata=0x55; par=odd correct -> 0.
//  4 Framing: stop bit 0 -> rferr=1 stored; 0.25-bit start glitch -> no entry, rcnt=0.
//  5 Overrun: DEPTH=8, receive 9 frames no pops -> rcnt=8, ovr=1, 9th dropped; clear -> rcnt=0, ovr=0.
//  6 Levels: rlvl=3 -> rintr rises cycle after 3rd store; wlvl=1, push 4 -> wintr 0, returns 1 at wcnt=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types, parity helpers and constants used by uart_core_p and its FIFOs.
package uart_pkg;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_st_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_st_e;
    typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} par_e;

    localparam int DIV_MIN = 3;

    // Code 3 is reserved and behaves as no parity.
    function automatic logic par_on(input logic [1:0] par);
        return (par_e'(par) == PAR_EVEN) || (par_e'(par) == PAR_ODD);
    endfunction

    function automatic logic par_bit(input logic [1:0] par, input logic [7:0] data);
        return (par_e'(par) == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy, next-state occupancy and flush; pointers one bit wider than the address.
import uart_pkg::*;

module uart_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   cnt,
    output logic [AW:0]   cnt_nxt,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic         do_push;
    logic         do_pop;

    assign cnt     = wp - rp;
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp[AW-1:0]];

    always_comb begin
        cnt_nxt = cnt;
        if (clear)
            cnt_nxt = '0;
        else if (do_push && !do_pop)
            cnt_nxt = cnt + ONE;
        else if (do_pop && !do_push)
            cnt_nxt = cnt - ONE;
    end

    // NOTE: storage has no reset; only the pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wp[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else if (clear) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push)
                wp <= wp + ONE;
            if (do_pop)
                rp <= rp + ONE;
        end
    end

endmodule

// File: rtl/uart_core_p.sv
// Full-duplex UART: baud-timed TX/RX FSMs, TX/RX FIFOs, RX error flags and level interrupts.
// Define UART_LOOPBACK_EN to add the lpbk port (internal tx feeds RX, tx pin held idle).
import uart_pkg::*;

module uart_core_p #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 8,
    parameter  int CW    = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clear,
    input  logic [CW-1:0] div,
    input  logic [1:0]    par,
    input  logic          stop2,
    input  logic          wvalid,
    output logic          wready,
    input  logic [DW-1:0] wdata,
    output logic          rvalid,
    input  logic          rready,
    output logic [DW-1:0] rdata,
    output logic          rperr,
    output logic          rferr,
    output logic          ovr,
    output logic [AW:0]   wcnt,
    output logic [AW:0]   rcnt,
    input  logic [AW:0]   wlvl,
    input  logic [AW:0]   rlvl,
    output logic          wintr,
    output logic          rintr,
    output logic          tx,
`ifdef UART_LOOPBACK_EN
    input  logic          lpbk,
`endif
    input  logic          rx
);

    localparam int IW = $clog2(DW);

    logic [CW-1:0] div_eff;
    logic [CW:0]   div_p1;
    logic [CW-1:0] rx_half;

    assign div_eff = (div < CW'(DIV_MIN)) ? CW'(DIV_MIN) : div;
    assign div_p1  = {1'b0, div_eff} + (CW+1)'(1);
    assign rx_half = CW'((div_p1 >> 1) - (CW+1)'(1));

    // ---------------- TX path ----------------
    tx_st_e        tx_st;
    logic [CW-1:0] tx_cnt;
    logic [DW-1:0] tx_sh;
    logic [IW-1:0] tx_idx;
    logic          tx_pbit;
    logic          tx_stop_2nd;
    logic          tx_q;
    logic [DW-1:0] tx_head;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_bnd;
    logic          tx_last_stop;
    logic          tx_pop;
    logic [AW:0]   wcnt_nxt;

    assign tx_bnd       = (tx_cnt == '0);
    assign tx_last_stop = (tx_st == TX_STOP) && tx_bnd && (!stop2 || tx_stop_2nd);
    // Head leaves the FIFO on the same edge the FSM enters START.
    assign tx_pop       = en && !tx_empty && ((tx_st == TX_IDLE) || tx_last_stop);

    uart_fifo #(.W(DW), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .push    (wvalid),
        .pop     (tx_pop),
        .din     (wdata),
        .dout    (tx_head),
        .cnt     (wcnt),
        .cnt_nxt (wcnt_nxt),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st       <= TX_IDLE;
            tx_cnt      <= '0;
            tx_sh       <= '0;
            tx_idx      <= '0;
            tx_pbit     <= 1'b0;
            tx_stop_2nd <= 1'b0;
            tx_q        <= 1'b1;
        end else if (!en) begin
            tx_st <= TX_IDLE;
            tx_q  <= 1'b1;
        end else if (tx_pop) begin
            tx_st   <= TX_START;
            tx_q    <= 1'b0;
            tx_cnt  <= div_eff;
            tx_sh   <= tx_head;
            tx_pbit <= par_bit(par, 8'(tx_head));
        end else begin
            case (tx_st)
                TX_IDLE: tx_q <= 1'b1;
                TX_START: begin
                    if (tx_bnd) begin
                        tx_st  <= TX_DATA;
                        tx_q   <= tx_sh[0];
                        tx_sh  <= tx_sh >> 1;
                        tx_idx <= '0;
                        tx_cnt <= div_eff;
                    end else begin
                        tx_cnt <= tx_cnt - CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_bnd) begin
                        tx_cnt <= div_eff;
                        if (tx_idx == IW'(DW - 1)) begin
                            if (par_on(par)) begin
                                tx_st <= TX_PAR;
                                tx_q  <= tx_pbit;
                            end else begin
                                tx_st       <= TX_STOP;
                                tx_q        <= 1'b1;
                                tx_stop_2nd <= 1'b0;
                            end
                        end else begin
                            tx_q   <= tx_sh[0];
                            tx_sh  <= tx_sh >> 1;
                            tx_idx <= tx_idx + IW'(1);
                        end
                    end else begin
                        tx_cnt <= tx_cnt - CW'(1);
                    end
                end
                TX_PAR: begin
                    if (tx_bnd) begin
                        tx_st       <= TX_STOP;
                        tx_q        <= 1'b1;
                        tx_stop_2nd <= 1'b0;
                        tx_cnt      <= div_eff;
                    end else begin
                        tx_cnt <= tx_cnt - CW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_bnd) begin
                        if (stop2 && !tx_stop_2nd) begin
                            tx_stop_2nd <= 1'b1;
                            tx_cnt      <= div_eff;
                        end else begin
                            tx_st <= TX_IDLE;
                            tx_q  <= 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - CW'(1);
                    end
                end
                default: begin
                    tx_st <= TX_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic rx_src;

`ifdef UART_LOOPBACK_EN
    assign rx_src = lpbk ? tx_q : rx;
    assign tx     = lpbk ? 1'b1 : tx_q;
`else
    assign rx_src = rx;
    assign tx     = tx_q;
`endif

    rx_st_e        rx_st;
    logic          rx_m;
    logic          rx_s;
    logic          rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [DW-1:0] rx_sh;
    logic [IW-1:0] rx_idx;
    logic          rx_perr;
    logic          rx_bnd;
    logic          rx_push;
    logic          rx_full;
    logic          rx_empty;
    logic [DW+1:0] rx_din;
    logic [DW+1:0] rx_dout;
    logic [AW:0]   rcnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= rx_src;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    assign rx_bnd  = (rx_cnt == '0);
    assign rx_push = en && (rx_st == RX_STOP) && rx_bnd;
    assign rx_din  = {~rx_s, rx_perr, rx_sh};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_st   <= RX_IDLE;
            rx_cnt  <= '0;
            rx_sh   <= '0;
            rx_idx  <= '0;
            rx_perr <= 1'b0;
        end else if (!en) begin
            rx_st <= RX_IDLE;
        end else begin
            case (rx_st)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_st   <= RX_START;
                        rx_cnt  <= rx_half;
                        rx_perr <= 1'b0;
                    end
                end
                RX_START: begin
                    if (rx_bnd) begin
                        if (rx_s) begin
                            rx_st <= RX_IDLE;
                        end else begin
                            rx_st  <= RX_DATA;
                            rx_idx <= '0;
                            rx_cnt <= div_eff;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_bnd) begin
                        rx_sh  <= {rx_s, rx_sh[DW-1:1]};
                        rx_cnt <= div_eff;
                        if (rx_idx == IW'(DW - 1))
                            rx_st <= par_on(par) ? RX_PAR : RX_STOP;
                        else
                            rx_idx <= rx_idx + IW'(1);
                    end else begin
                        rx_cnt <= rx_cnt - CW'(1);
                    end
                end
                RX_PAR: begin
                    if (rx_bnd) begin
                        rx_perr <= (rx_s != par_bit(par, 8'(rx_sh)));
                        rx_st   <= RX_STOP;
                        rx_cnt  <= div_eff;
                    end else begin
                        rx_cnt <= rx_cnt - CW'(1);
                    end
                end
                RX_STOP: begin
                    // Leaves at mid-stop so the next start edge is caught despite rate mismatch.
                    if (rx_bnd)
                        rx_st <= RX_IDLE;
                    else
                        rx_cnt <= rx_cnt - CW'(1);
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    uart_fifo #(.W(DW + 2), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .push    (rx_push),
        .pop     (rready),
        .din     (rx_din),
        .dout    (rx_dout),
        .cnt     (rcnt),
        .cnt_nxt (rcnt_nxt),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovr <= 1'b0;
        else if (clear)
            ovr <= 1'b0;
        else if (rx_push && rx_full)
            ovr <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wintr <= 1'b1;
            rintr <= 1'b0;
        end else begin
            wintr <= (wcnt_nxt <= wlvl);
            rintr <= (rlvl != '0) && (rcnt_nxt >= rlvl);
        end
    end

    assign wready = !tx_full;
    assign rvalid = !rx_empty;
    assign rdata  = rx_dout[DW-1:0];
    assign rperr  = rvalid && rx_dout[DW];
    assign rferr  = rvalid && rx_dout[DW+1];

endmodule

// File: tb/tb_uart_core_p.sv
// Self-checking bench for uart_core_p: vector table, hand sequences and randomized loopback vs. a queue model.
`timescale 1ns/1ps

module tb_uart_core_p;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst, en, clear, stop2, wvalid, rready, rx_drv, loop;
    logic [CW-1:0] div;
    logic [1:0]    par;
    logic [DW-1:0] wdata, rdata;
    logic          wready, rvalid, rperr, rferr, ovr, wintr, rintr, tx, rx;
    logic [AW:0]   wcnt, rcnt, wlvl, rlvl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    assign rx = loop ? tx : rx_drv;

    uart_core_p #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .clear  (clear),
        .div    (div),
        .par    (par),
        .stop2  (stop2),
        .wvalid (wvalid),
        .wready (wready),
        .wdata  (wdata),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata),
        .rperr  (rperr),
        .rferr  (rferr),
        .ovr    (ovr),
        .wcnt   (wcnt),
        .rcnt   (rcnt),
        .wlvl   (wlvl),
        .rlvl   (rlvl),
        .wintr  (wintr),
        .rintr  (rintr),
        .tx     (tx),
`ifdef UART_LOOPBACK_EN
        .lpbk   (1'b0),
`endif
        .rx     (rx)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] par;
        bit         flip;
        bit         stop_bit;
        bit         exp_perr;
        bit         exp_ferr;
    } rxvec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] d);
        wvalid = 1'b1;
        wdata  = d;
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic pop();
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Parity bit that makes the total count of ones even (even) or odd (odd).
    function automatic logic model_par(input logic [1:0] p, input logic [7:0] d);
        int ones;
        ones = $countones(d);
        return (p == 2'd2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    function automatic bit has_par(input logic [1:0] p);
        return (p == 2'd1) || (p == 2'd2);
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop_bit);
        int bt;
        bt = int'(div) + 1;
        rx_drv = 1'b0;
        cycles(bt);
        for (int i = 0; i < DW; i++) begin
            rx_drv = d[i];
            cycles(bt);
        end
        if (has_par(par)) begin
            rx_drv = model_par(par, d) ^ flip;
            cycles(bt);
        end
        rx_drv = stop_bit;
        cycles(bt);
        rx_drv = 1'b1;
        cycles(4);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rxvec_t         vecs [6];
        logic [DW-1:0]  q [$];
        logic [DW-1:0]  d;
        logic [0:21]    exp_bits;
        logic [7:0]     lb_data [2];
        int             n, errs, kc, nf;
        logic           prev_ri;

        rst = 1'b0; en = 1'b0; clear = 1'b0; stop2 = 1'b0; wvalid = 1'b0; rready = 1'b0;
        rx_drv = 1'b1; loop = 1'b0; div = 16'd7; par = 2'd0; wdata = '0;
        wlvl = '0; rlvl = '0;
        #2 rst = 1'b1;
        cycles(3);

        // Reset state
        check("rst_tx", tx, 1);
        check("rst_wcnt", wcnt, 0);
        check("rst_rcnt", rcnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_wready", wready, 1);
        check("rst_ovr", ovr, 0);
        check("rst_wintr", wintr, 1);
        check("rst_rintr", rintr, 0);
        check("rst_rperr", rperr, 0);
        check("rst_rferr", rferr, 0);
        rst = 1'b0;
        en  = 1'b1;
        cycles(4);

        // Table of received frames: parity and framing errors
        vecs[0] = '{8'h55, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h55, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'h3C, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            par = vecs[i].par;
            send_frame(vecs[i].data, vecs[i].flip, vecs[i].stop_bit);
            check($sformatf("vec%0d_rvalid", i), rvalid, 1);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].data);
            check($sformatf("vec%0d_rperr", i), rperr, vecs[i].exp_perr);
            check($sformatf("vec%0d_rferr", i), rferr, vecs[i].exp_ferr);
            pop();
            check($sformatf("vec%0d_popped", i), rvalid, 0);
        end

        // Quarter-bit start glitch stores nothing
        par = 2'd0;
        rx_drv = 1'b0;
        cycles(2);
        rx_drv = 1'b1;
        cycles(100);
        check("glitch_rcnt", rcnt, 0);
        check("glitch_rvalid", rvalid, 0);

        // Overrun with rlvl=3: nine frames, no pops
        rlvl = 3;
        for (int k = 1; k <= 9; k++) begin
            d = DW'($urandom);
            send_frame(d, 1'b0, 1'b1);
            if (k <= DEPTH) q.push_back(d);
            kc = (k < DEPTH) ? k : DEPTH;
            check($sformatf("ovr_rcnt_%0d", k), rcnt, kc);
            check($sformatf("ovr_rintr_%0d", k), rintr, (kc >= 3));
            check($sformatf("ovr_flag_%0d", k), ovr, (k > DEPTH));
        end
        check("ovr_wready_full_rx", rvalid, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovr_head_%0d", i), rdata, q.pop_front());
            pop();
        end
        check("ovr_after_pops", rcnt, DEPTH - 4);
        pulse_clear();
        check("clear_rcnt", rcnt, 0);
        check("clear_ovr", ovr, 0);
        check("clear_rvalid", rvalid, 0);
        check("clear_rintr", rintr, 0);
        q.delete();

        // rintr rises together with rcnt reaching rlvl
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h02, 1'b0, 1'b1);
        fork
            send_frame(8'h03, 1'b0, 1'b1);
            begin
                n = 0;
                prev_ri = rintr;
                while (rcnt != 3 && n < 300) begin
                    prev_ri = rintr;
                    @(negedge clk);
                    n++;
                end
                check("rintr_wait", (n < 300), 1);
                check("rintr_before3", prev_ri, 0);
                check("rintr_at3", rintr, 1);
            end
        join
        pulse_clear();
        rlvl = 0;

        // wintr with wlvl=1: low while full-ish, high again at wcnt=1
        wlvl = 1;
        en = 1'b0;
        for (int i = 0; i < 4; i++) push(DW'(8'h10 + i));
        check("wlvl_wcnt4", wcnt, 4);
        check("wlvl_wintr_low", wintr, 0);
        en = 1'b1;
        n = 0;
        while (wcnt != 2 && n < 300) begin @(negedge clk); n++; end
        check("wlvl_wait2", (n < 300), 1);
        check("wlvl_wintr_at2", wintr, 0);
        n = 0;
        while (wcnt != 1 && n < 300) begin @(negedge clk); n++; end
        check("wlvl_wait1", (n < 300), 1);
        check("wlvl_wintr_at1", wintr, 1);
        cycles(400);
        check("wlvl_drained", wcnt, 0);
        wlvl = 0;

        // Loopback, div=7, even parity: 0xA5 then 0x3C, 11 bits x 8 cycles, no gap
        loop = 1'b1;
        par  = 2'd1;
        div  = 16'd7;
        en   = 1'b0;
        lb_data[0] = 8'hA5;
        lb_data[1] = 8'h3C;
        push(lb_data[0]);
        push(lb_data[1]);
        check("lb_wcnt2", wcnt, 2);
        for (int f = 0; f < 2; f++) begin
            exp_bits[f*11] = 1'b0;
            for (int b = 0; b < 8; b++) exp_bits[f*11 + 1 + b] = lb_data[f][b];
            exp_bits[f*11 + 9]  = model_par(2'd1, lb_data[f]);
            exp_bits[f*11 + 10] = 1'b1;
        end
        en = 1'b1;
        n = 0;
        while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        check("lb_start_seen", (n < 50), 1);
        check("lb_wcnt_popped", wcnt, 1);
        errs = 0;
        for (int k = 0; k < 176; k++) begin
            if (tx !== exp_bits[k / 8]) errs++;
            @(negedge clk);
        end
        check("lb_tx_wave_errs", errs, 0);
        check("lb_tx_idle", tx, 1);
        check("lb_wcnt0", wcnt, 0);
        cycles(10);
        check("lb_rcnt", rcnt, 2);
        for (int f = 0; f < 2; f++) begin
            check($sformatf("lb_rdata%0d", f), rdata, lb_data[f]);
            check($sformatf("lb_rperr%0d", f), rperr, 0);
            check($sformatf("lb_rferr%0d", f), rferr, 0);
            pop();
        end

        // Randomized loopback configs against a queue model
        for (int r = 0; r < 4; r++) begin
            en    = 1'b0;
            div   = CW'($urandom_range(3, 10));
            par   = 2'($urandom_range(0, 3));
            stop2 = 1'($urandom_range(0, 1));
            nf    = $urandom_range(2, 5);
            for (int i = 0; i < nf; i++) begin
                d = DW'($urandom);
                q.push_back(d);
                push(d);
            end
            en = 1'b1;
            cycles(nf * 13 * (int'(div) + 1) + 20);
            check($sformatf("rnd%0d_wcnt", r), wcnt, 0);
            check($sformatf("rnd%0d_rcnt", r), rcnt, nf);
            for (int i = 0; i < nf; i++) begin
                d = q.pop_front();
                check($sformatf("rnd%0d_rdata%0d", r, i), rdata, d);
                check($sformatf("rnd%0d_err%0d", r, i), {rperr, rferr}, 0);
                pop();
            end
        end

        // Asynchronous reset in the middle of a TX frame
        loop  = 1'b0;
        par   = 2'd0;
        stop2 = 1'b0;
        div   = 16'd7;
        rlvl  = 1;
        send_frame(8'h5A, 1'b0, 1'b1);
        check("pre_rst_rintr", rintr, 1);
        push(8'hC3);
        push(8'h96);
        cycles(30);
        check("pre_rst_wcnt", wcnt, 1);
        check("pre_rst_tx_busy", (tx === 1'b0) || (tx === 1'b1), 1);
        #3 rst = 1'b1;
        #1;
        check("midtx_rst_tx", tx, 1);
        check("midtx_rst_wcnt", wcnt, 0);
        check("midtx_rst_rcnt", rcnt, 0);
        check("midtx_rst_rintr", rintr, 0);
        check("midtx_rst_wintr", wintr, 1);
        check("midtx_rst_rvalid", rvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
